// File: rtl/gpc_pipe_acc.sv
// gpc_pipe_acc: two-stage weighted popcount (columns of weight 1/2/4) feeding
// either a per-beat result or a saturating frame accumulator, behind valid/ready.
module gpc_pipe_acc #(
  parameter int H0    = 7,
  parameter int H1    = 1,
  parameter int H2    = 1,
  parameter int ACC_W = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic                            in_last,
  input  logic                            mode,
  input  logic [H0-1:0]                   src0,
  input  logic [((H1 > 0) ? H1 : 1)-1:0]  src1,
  input  logic [((H2 > 0) ? H2 : 1)-1:0]  src2,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [ACC_W-1:0]                dst,
  output logic                            acc_ovf
);

  // Handshake: a beat moves on in_valid && in_ready, a result leaves on
  // out_valid && out_ready; both stages advance together only when the output
  // register is empty or being drained, so in_ready is exactly that enable.

  localparam int SUM_W = $clog2(H0 + 2*H1 + 4*H2 + 1);
  localparam int W1    = (H1 > 0) ? H1 : 1;
  localparam int W2    = (H2 > 0) ? H2 : 1;
  localparam int PC_W  = 5;
  localparam logic [ACC_W-1:0] ACC_MAX = '1;

  if (ACC_W < SUM_W) begin : g_bad_acc_w
    $error("gpc_pipe_acc: ACC_W must be at least SUM_W");
  end

  function automatic logic [PC_W-1:0] popcnt16(input logic [15:0] v);
    logic [PC_W-1:0] c;
    c = '0;
    for (int i = 0; i < 16; i++) c = c + PC_W'(v[i]);
    return c;
  endfunction

  logic             w_en;
  logic [15:0]      w_x0, w_x1, w_x2;
  logic [SUM_W-1:0] w_sum;
  logic [ACC_W:0]   w_sum_ext;
  logic [ACC_W:0]   w_acc_full;
  logic             w_new_ovf;
  logic [ACC_W-1:0] w_acc_sat;

  logic             r_s1_valid, r_s1_mode, r_s1_last;
  logic [PC_W-1:0]  r_p0, r_p1, r_p2;
  logic [ACC_W-1:0] r_acc;
  logic             r_ovf_sticky;
  logic             r_out_valid;
  logic [ACC_W-1:0] r_dst;
  logic             r_acc_ovf;

  assign w_en     = !r_out_valid || out_ready;
  assign in_ready = w_en && !rst;

  // Zero-width columns keep a 1-bit stub port that is never counted.
  always_comb begin
    w_x0 = '0;
    w_x1 = '0;
    w_x2 = '0;
    w_x0[H0-1:0] = src0;
    if (H1 > 0) w_x1[W1-1:0] = src1;
    if (H2 > 0) w_x2[W2-1:0] = src2;
  end

  assign w_sum      = SUM_W'(r_p0) + SUM_W'({r_p1, 1'b0}) + SUM_W'({r_p2, 2'b0});
  assign w_sum_ext  = (ACC_W + 1)'(w_sum);
  assign w_acc_full = {1'b0, r_acc} + w_sum_ext;
  // acc <= max and sum < 2^ACC_W, so the carry bit alone marks overflow.
  assign w_new_ovf  = w_acc_full[ACC_W];
  assign w_acc_sat  = w_new_ovf ? ACC_MAX : w_acc_full[ACC_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_mode  <= 1'b0;
      r_s1_last  <= 1'b0;
      r_p0       <= '0;
      r_p1       <= '0;
      r_p2       <= '0;
    end else if (w_en) begin
      r_s1_valid <= in_valid;
      r_s1_mode  <= mode;
      r_s1_last  <= in_last;
      r_p0       <= popcnt16(w_x0);
      r_p1       <= popcnt16(w_x1);
      r_p2       <= popcnt16(w_x2);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_dst        <= '0;
      r_acc_ovf    <= 1'b0;
      r_acc        <= '0;
      r_ovf_sticky <= 1'b0;
    end else if (w_en) begin
      r_out_valid <= 1'b0;
      if (r_s1_valid) begin
        if (!r_s1_mode) begin
          r_out_valid <= 1'b1;
          r_dst       <= w_sum_ext[ACC_W-1:0];
          r_acc_ovf   <= 1'b0;
        end else if (r_s1_last) begin
          r_out_valid  <= 1'b1;
          r_dst        <= w_acc_sat;
          r_acc_ovf    <= r_ovf_sticky | w_new_ovf;
          r_acc        <= '0;
          r_ovf_sticky <= 1'b0;
        end else begin
          r_acc        <= w_acc_sat;
          r_ovf_sticky <= r_ovf_sticky | w_new_ovf;
        end
      end
    end
  end

  assign out_valid = r_out_valid;
  assign dst       = r_dst;
  assign acc_ovf   = r_acc_ovf;

endmodule
